// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: runs the req/gnt/rvalid data-memory handshake and emits one write-back beat per instruction.
// Optional abort-on-timeout build: define MEM_TIMEOUT_EN.
module mem_access_ctrl #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              in_valid_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic              mem_to_reg_i,
   input  logic              reg_write_i,
   input  logic [4:0]        rd_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              stall_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [ADDR_W-1:0] dmem_addr_o,
   output logic [DATA_W-1:0] dmem_wdata_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [DATA_W-1:0] dmem_rdata_i,
   output logic              wb_valid_o,
   output logic              wb_reg_write_o,
   output logic [4:0]        wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_e;

   state_e              state_q, state_d;

   logic                reg_write_q;
   logic                mem_to_reg_q;
   logic [4:0]          rd_q;
   logic [DATA_W-1:0]   alu_q;

   logic                capture;
   logic                wb_load;
   logic                wb_reg_write_d;
   logic [4:0]          wb_rd_d;
   logic [DATA_W-1:0]   wb_data_d;
   logic                err_d;
   logic                timeout_hit;
   logic                mem_op;

   assign mem_op = mem_read_i | mem_write_i;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   assign timeout_hit = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

   // Held at zero in IDLE so it starts from zero on every entry to REQ.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
      end else if (!timeout_hit) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
   assign timeout_hit        = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, handshake outputs and write-back selection.
   always_comb begin
      state_d        = state_q;
      capture        = 1'b0;
      wb_load        = 1'b0;
      wb_reg_write_d = 1'b0;
      wb_rd_d        = rd_q;
      wb_data_d      = alu_q;
      err_d          = 1'b0;
      stall_o        = 1'b0;
      dmem_req_o     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               if (mem_op) begin
                  stall_o = 1'b1;
                  capture = 1'b1;
                  state_d = REQ;
               end else begin
                  wb_load        = 1'b1;
                  wb_reg_write_d = reg_write_i;
                  wb_rd_d        = rd_i;
                  wb_data_d      = alu_result_i;
               end
            end
         end
         REQ: begin
            if (timeout_hit) begin
               wb_load = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               dmem_req_o = 1'b1;
               stall_o    = 1'b1;
               if (dmem_gnt_i) begin
                  if (dmem_we_o) begin
                     stall_o = 1'b0;
                     wb_load = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (timeout_hit) begin
               wb_load = 1'b1;
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (dmem_rvalid_i) begin
               wb_load        = 1'b1;
               wb_reg_write_d = reg_write_q;
               wb_data_d      = mem_to_reg_q ? dmem_rdata_i : alu_q;
               state_d        = IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Instruction capture; the request fields drive memory directly from these flops.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         dmem_we_o    <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_wdata_o <= '0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         rd_q         <= '0;
         alu_q        <= '0;
      end else if (capture) begin
         dmem_we_o    <= mem_write_i & ~mem_read_i;
         dmem_addr_o  <= addr_i;
         dmem_wdata_o <= wdata_i;
         reg_write_q  <= reg_write_i;
         mem_to_reg_q <= mem_to_reg_i;
         rd_q         <= rd_i;
         alu_q        <= alu_result_i;
      end
   end

   // Write-back beat: valid/err pulse, payload holds between beats.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wb_valid_o     <= 1'b0;
         wb_reg_write_o <= 1'b0;
         wb_rd_o        <= '0;
         wb_data_o      <= '0;
         err_o          <= 1'b0;
      end else begin
         wb_valid_o <= wb_load;
         err_o      <= err_d;
         if (wb_load) begin
            wb_reg_write_o <= wb_reg_write_d;
            wb_rd_o        <= wb_rd_d;
            wb_data_o      <= wb_data_d;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected write-back beats are queued at stimulus time and checked by a monitor.
module tb_mem_access_ctrl;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned TMO    = 4;

   logic              clk_i, reset_ni;
   logic              in_valid_i, mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i;
   logic [4:0]        rd_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] wdata_i, alu_result_i;
   logic              stall_o, dmem_req_o, dmem_we_o;
   logic [ADDR_W-1:0] dmem_addr_o;
   logic [DATA_W-1:0] dmem_wdata_o;
   logic              dmem_gnt_i, dmem_rvalid_i;
   logic [DATA_W-1:0] dmem_rdata_i;
   logic              wb_valid_o, wb_reg_write_o;
   logic [4:0]        wb_rd_o;
   logic [DATA_W-1:0] wb_data_o;
   logic              err_o;

   typedef struct packed {
      logic              reg_write;
      logic [4:0]        rd;
      logic [DATA_W-1:0] data;
      logic              err;
      logic              full;  // compare rd/data too
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   mem_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
      .reg_write_i(reg_write_i), .rd_i(rd_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .alu_result_i(alu_result_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o),
      .wb_data_o(wb_data_o), .err_o(err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Monitor: every write-back beat must match the head of the scoreboard.
   always @(negedge clk_i) begin
      if (reset_ni) begin
         if (wb_valid_o) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_wb_beat got rd=%0d data=%h, no beat expected", wb_rd_o, wb_data_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (wb_reg_write_o !== mon_e.reg_write) begin
                  bad++;
                  $display("FAIL wb_reg_write got=%b want=%b", wb_reg_write_o, mon_e.reg_write);
               end
               total++;
               if (err_o !== mon_e.err) begin
                  bad++;
                  $display("FAIL wb_err got=%b want=%b", err_o, mon_e.err);
               end
               if (mon_e.full) begin
                  total++;
                  if (wb_rd_o !== mon_e.rd) begin
                     bad++;
                     $display("FAIL wb_rd got=%0d want=%0d", wb_rd_o, mon_e.rd);
                  end
                  total++;
                  if (wb_data_o !== mon_e.data) begin
                     bad++;
                     $display("FAIL wb_data got=%h want=%h", wb_data_o, mon_e.data);
                  end
               end
            end
         end else begin
            total++;
            if (err_o !== 1'b0) begin
               bad++;
               $display("FAIL err_without_beat got=%b want=0", err_o);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid_i    = 1'b0;
      mem_read_i    = 1'b0;
      mem_write_i   = 1'b0;
      mem_to_reg_i  = 1'b0;
      reg_write_i   = 1'b0;
      rd_i          = '0;
      addr_i        = '0;
      wdata_i       = '0;
      alu_result_i  = '0;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = '0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 16 && exp_q.size() != 0; i++) step();
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      idle_inputs();
      #1;
      total++;
      if ({dmem_req_o, dmem_we_o, stall_o, wb_valid_o, wb_reg_write_o, err_o} !== 6'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=000000",
                  {dmem_req_o, dmem_we_o, stall_o, wb_valid_o, wb_reg_write_o, err_o});
      end
      total++;
      if ({dmem_addr_o, dmem_wdata_o} !== 64'h0) begin
         bad++;
         $display("FAIL reset_dmem got=%h_%h want=0", dmem_addr_o, dmem_wdata_o);
      end
      total++;
      if ({wb_rd_o, wb_data_o} !== 37'h0) begin
         bad++;
         $display("FAIL reset_wb got rd=%0d data=%h want=0", wb_rd_o, wb_data_o);
      end
      step();
      step();
      reset_ni = 1'b1;
      step();
      total++;
      if ({stall_o, dmem_req_o, wb_valid_o} !== 3'b0) begin
         bad++;
         $display("FAIL post_reset_idle got=%b want=000", {stall_o, dmem_req_o, wb_valid_o});
      end
   endtask

   task automatic test_rtype();
      step();
      in_valid_i = 1'b1; reg_write_i = 1'b1; rd_i = 5'd5; alu_result_i = 32'h1234;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd5, data: 32'h1234, err: 1'b0, full: 1'b1});
      #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL rtype_stall1 got=%b want=0", stall_o); end
      step();
      reg_write_i = 1'b0; rd_i = 5'd31; alu_result_i = 32'hFFFF_FFFF;
      exp_q.push_back('{reg_write: 1'b0, rd: 5'd31, data: 32'hFFFF_FFFF, err: 1'b0, full: 1'b1});
      #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL rtype_stall2 got=%b want=0", stall_o); end
      step();
      idle_inputs();
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL rtype_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_store();
      step();
      in_valid_i = 1'b1; mem_write_i = 1'b1; reg_write_i = 1'b1; rd_i = 5'd3;
      addr_i = 32'h40; wdata_i = 32'hDEAD_BEEF; alu_result_i = 32'h55;
      #1;
      total++;
      if (stall_o !== 1'b1) begin bad++; $display("FAIL store_stall_idle got=%b want=1", stall_o); end
      for (int i = 0; i < 3; i++) begin
         step();
         dmem_gnt_i = (i == 2);
         if (i == 2) exp_q.push_back('{reg_write: 1'b0, rd: 5'd0, data: '0, err: 1'b0, full: 1'b0});
         #1;
         total++;
         if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL store_req_c%0d got req=%b we=%b addr=%h wdata=%h want 1 1 40 deadbeef",
                     i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o);
         end
         total++;
         if (stall_o !== (i != 2)) begin
            bad++; $display("FAIL store_stall_c%0d got=%b want=%b", i, stall_o, (i != 2));
         end
      end
      step();
      idle_inputs();
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL store_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_load();
      step();
      in_valid_i = 1'b1; mem_read_i = 1'b1; mem_to_reg_i = 1'b1; reg_write_i = 1'b1;
      rd_i = 5'd7; addr_i = 32'h80; alu_result_i = 32'h11;
      step();
      dmem_gnt_i = 1'b1;
      #1;
      total++;
      if ({dmem_req_o, dmem_we_o, dmem_addr_o, stall_o} !== {2'b10, 32'h80, 1'b1}) begin
         bad++;
         $display("FAIL load_req got req=%b we=%b addr=%h stall=%b want 1 0 80 1",
                  dmem_req_o, dmem_we_o, dmem_addr_o, stall_o);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         dmem_gnt_i    = 1'b0;
         dmem_rvalid_i = (i == 3);
         dmem_rdata_i  = (i == 3) ? 32'hCAFE_F00D : 32'h0;
         if (i == 3) exp_q.push_back('{reg_write: 1'b1, rd: 5'd7, data: 32'hCAFE_F00D, err: 1'b0, full: 1'b1});
         #1;
         total++;
         if ({dmem_req_o, stall_o} !== {1'b0, (i != 3)}) begin
            bad++; $display("FAIL load_wait_c%0d got req=%b stall=%b want 0 %b", i, dmem_req_o, stall_o, (i != 3));
         end
      end
      step();
      idle_inputs();
      // Load with ALU write-back, rvalid during REQ must be ignored.
      in_valid_i = 1'b1; mem_read_i = 1'b1; reg_write_i = 1'b1; rd_i = 5'd12;
      addr_i = 32'h84; alu_result_i = 32'h77;
      step();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h999;
      #1;
      total++;
      if ({dmem_req_o, stall_o} !== 2'b11) begin
         bad++; $display("FAIL load_rvalid_in_req got req=%b stall=%b want 1 1", dmem_req_o, stall_o);
      end
      step();
      dmem_rvalid_i = 1'b0; dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd12, data: 32'h77, err: 1'b0, full: 1'b1});
      #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL load_alu_stall got=%b want=0", stall_o); end
      step();
      idle_inputs();
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL load_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_back_to_back();
      step();
      in_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b1; mem_to_reg_i = 1'b1;
      reg_write_i = 1'b1; rd_i = 5'd9; addr_i = 32'h100; wdata_i = 32'hAAAA; alu_result_i = 32'h5;
      step();
      dmem_gnt_i = 1'b1;
      #1;
      total++;
      if ({dmem_req_o, dmem_we_o} !== 2'b10) begin
         bad++; $display("FAIL b2b_rw_is_load got req=%b we=%b want 1 0", dmem_req_o, dmem_we_o);
      end
      step();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1357_2468;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd9, data: 32'h1357_2468, err: 1'b0, full: 1'b1});
      step();
      idle_inputs();
      in_valid_i = 1'b1; reg_write_i = 1'b1; rd_i = 5'd10; alu_result_i = 32'hABCD;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd10, data: 32'hABCD, err: 1'b0, full: 1'b1});
      #1;
      total++;
      if ({wb_valid_o, wb_rd_o, stall_o} !== {1'b1, 5'd9, 1'b0}) begin
         bad++; $display("FAIL b2b_load_beat got v=%b rd=%0d stall=%b want 1 9 0", wb_valid_o, wb_rd_o, stall_o);
      end
      step();
      idle_inputs();
      total++;
      if ({wb_valid_o, wb_rd_o} !== {1'b1, 5'd10}) begin
         bad++; $display("FAIL b2b_rtype_beat got v=%b rd=%0d want 1 10", wb_valid_o, wb_rd_o);
      end
      step();
      total++;
      if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b want=0", wb_valid_o); end
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      step();
      in_valid_i = 1'b1; mem_read_i = 1'b1; mem_to_reg_i = 1'b1; reg_write_i = 1'b1;
      rd_i = 5'd4; addr_i = 32'h200;
      step();
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      reset_ni = 1'b0;
      idle_inputs();
      #1;
      total++;
      if ({dmem_req_o, dmem_we_o, stall_o, wb_valid_o, err_o, dmem_addr_o} !== {5'b0, 32'h0}) begin
         bad++;
         $display("FAIL midreset_outputs got req=%b we=%b stall=%b wbv=%b err=%b addr=%h want all 0",
                  dmem_req_o, dmem_we_o, stall_o, wb_valid_o, err_o, dmem_addr_o);
      end
      step();
      reset_ni = 1'b1;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBAD;
      #1;
      total++;
      if ({stall_o, dmem_req_o} !== 2'b00) begin
         bad++; $display("FAIL midreset_late_rvalid got stall=%b req=%b want 0 0", stall_o, dmem_req_o);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         dmem_rvalid_i = 1'b0;
         total++;
         if (wb_valid_o !== 1'b0) begin bad++; $display("FAIL midreset_no_beat_c%0d got=%b want=0", i, wb_valid_o); end
      end
      in_valid_i = 1'b1; reg_write_i = 1'b1; rd_i = 5'd6; alu_result_i = 32'h66;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd6, data: 32'h66, err: 1'b0, full: 1'b1});
      step();
      idle_inputs();
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL midreset_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   task automatic test_timeout();
      step();
      in_valid_i = 1'b1; mem_read_i = 1'b1; mem_to_reg_i = 1'b1; reg_write_i = 1'b1;
      rd_i = 5'd8; addr_i = 32'hC0;
`ifdef MEM_TIMEOUT_EN
      for (int i = 0; i < int'(TMO); i++) begin
         step();
         total++;
         if ({dmem_req_o, stall_o} !== 2'b11) begin
            bad++; $display("FAIL tmo_req_c%0d got req=%b stall=%b want 1 1", i, dmem_req_o, stall_o);
         end
      end
      step();
      exp_q.push_back('{reg_write: 1'b0, rd: 5'd0, data: '0, err: 1'b1, full: 1'b0});
      total++;
      if ({dmem_req_o, stall_o} !== 2'b00) begin
         bad++; $display("FAIL tmo_abort got req=%b stall=%b want 0 0", dmem_req_o, stall_o);
      end
      step();
      idle_inputs();
      step();
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h4444;
      #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL tmo_late_rvalid got stall=%b want 0", stall_o); end
      step();
      dmem_rvalid_i = 1'b0;
`else
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if ({dmem_req_o, stall_o} !== 2'b11) begin
            bad++; $display("FAIL notmo_hold_c%0d got req=%b stall=%b want 1 1", i, dmem_req_o, stall_o);
         end
      end
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8888;
      exp_q.push_back('{reg_write: 1'b1, rd: 5'd8, data: 32'h8888, err: 1'b0, full: 1'b1});
      step();
      idle_inputs();
`endif
      wait_drain();
      total++;
      if (exp_q.size() != 0) begin
         bad++; $display("FAIL tmo_drain pending=%0d want=0", exp_q.size()); exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_store();
      test_load();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage sequencer that sits directly downstream of the opcode control decoder. It consumes the decoded mem_read/mem_write/mem_to_reg/reg_write flags plus the address, store data and ALU result. It runs a req/gnt/rvalid handshake to data memory and stalls upstream until the access completes. It then produces one registered write-back beat per instruction.

Parameters:
DATA_W, 32, data bus and register width
ADDR_W, 32, data memory byte-address width
TIMEOUT_CYCLES, 64, cycles in REQ+WAIT before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  instruction present on inputs
mem_read_i  in  1  load access
mem_write_i  in  1  store access
mem_to_reg_i  in  1  write-back selects memory data (1) or ALU result (0)
reg_write_i  in  1  instruction writes rd
rd_i  in  5  destination register
addr_i  in  ADDR_W  memory address
wdata_i  in  DATA_W  store data
alu_result_i  in  DATA_W  ALU result
stall_o  out  1  hold upstream inputs stable
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = write
dmem_addr_o  out  ADDR_W  request address
dmem_wdata_o  out  DATA_W  store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  DATA_W  read data
wb_valid_o  out  1  write-back beat
wb_reg_write_o  out  1  write-back enable
wb_rd_o  out  5  write-back register
wb_data_o  out  DATA_W  write-back data
err_o  out  1  access aborted (timeout)

Behaviour:
- Reset (async, reset_ni=0): state IDLE; all outputs 0; captured registers 0. Reset mid-access aborts with no write-back beat. Any later rvalid/gnt is ignored while in IDLE.
- FSM states: IDLE, REQ, WAIT.
- IDLE, in_valid_i=1, no memory op:
  - Next edge: wb_valid_o=1, wb_reg_write_o=reg_write_i, wb_rd_o=rd_i, wb_data_o=alu_result_i.
  - Latency 1, stall_o=0.
- IDLE, in_valid_i=1, memory op:
  - stall_o=1 combinationally.
  - Edge: capture addr, wdata, rd, reg_write, mem_to_reg, alu_result and we (=mem_write_i & ~mem_read_i); go to REQ.
  - mem_read_i and mem_write_i both 1: treated as a load.
- REQ:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o and dmem_wdata_o are driven from captured values and held stable until gnt.
  - gnt with we=1 (store): stall_o=0 this cycle. Next edge: wb_valid_o=1, wb_reg_write_o=0, go to IDLE.
  - gnt with we=0 (load): go to WAIT, stall_o stays 1.
- WAIT:
  - dmem_req_o=0; stall_o=1 until the cycle dmem_rvalid_i=1, in which stall_o=0.
  - Next edge: wb_valid_o=1, wb_rd_o=captured rd, wb_reg_write_o=captured reg_write.
  - wb_data_o = dmem_rdata_i if captured mem_to_reg=1, else captured alu_result. Go to IDLE.
- rvalid in REQ or IDLE: ignored. Memory must return rvalid no earlier than the cycle after gnt.
- wb_valid_o is a single-cycle pulse; wb_* fields hold their last values when wb_valid_o=0.
- Upstream advances on the edge where stall_o=0; each instruction is captured exactly once.
- No address alignment checking; addr passes through unmodified.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a cycle counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entry to REQ and increments in REQ/WAIT.
- When the counter reaches TIMEOUT_CYCLES: dmem_req_o drops, stall_o=0 that cycle.
- Next edge: err_o=1 for one cycle, wb_valid_o=1, wb_reg_write_o=0, go to IDLE.
- A late rvalid after the abort is ignored.
- Undefined: no counter; the block waits indefinitely and err_o is tied 0.

Test Plan:
- R-type: in_valid=1, reg_write=1, rd=5, alu=0x1234, no mem op -> next cycle wb_valid=1, rd=5, data=0x1234, stall_o never 1.
- Store: mem_write=1, addr=0x40, wdata=0xDEADBEEF, gnt after 2 REQ cycles -> req/we/addr/wdata stable for 3 cycles, stall_o=1 until gnt, then wb_valid=1 with wb_reg_write=0.
- Load: mem_read=1, mem_to_reg=1, rd=7, addr=0x80, gnt on first cycle, rvalid 3 cycles later with 0xCAFEF00D -> wb_data=0xCAFEF00D, rd=7, reg_write=1, exactly one wb beat.
- Back-to-back load then R-type, inputs held under stall -> load written back once, R-type written back one cycle after the load beat, no duplicate capture.
- Reset asserted in WAIT, then rvalid=1 after release -> all outputs 0, no wb beat, FSM in IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load with no gnt -> req for 4 cycles, then err_o=1 and wb_valid=1 with wb_reg_write=0; without the macro, stall_o stays 1 indefinitely.
